// File: rtl/ddr_pkg.sv
// Shared constants for the DDR hit-judge slice: judgement encoding, lane
// indices, FSM states and the score ceiling.
package ddr_pkg;

  localparam logic [1:0] JUDGE_NONE    = 2'd0;
  localparam logic [1:0] JUDGE_MISS    = 2'd1;
  localparam logic [1:0] JUDGE_GOOD    = 2'd2;
  localparam logic [1:0] JUDGE_PERFECT = 2'd3;

  localparam int LANE_U = 3;
  localparam int LANE_D = 2;
  localparam int LANE_L = 1;
  localparam int LANE_R = 0;

  localparam int SCORE_MAX_DFLT = 9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Score multiplier from the combo count held before this cycle's update.
  function automatic logic [7:0] combo_mult(input logic [7:0] combo,
                                            input int step,
                                            input int max_mult);
    int m;
    m = 1 + int'(combo) / step;
    if (m > max_mult) m = max_mult;
    return 8'(m);
  endfunction

endpackage

// File: rtl/hit_judge_lane_classify.sv
// One lane of the hit judge: rising-edge detect on the debounced button and
// the first pipeline stage that classifies a press as PERFECT, GOOD or MISS.
import ddr_pkg::*;

module lane_classify (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       in_zone,
  input  logic       perfect,
  input  logic       enable,
  output logic       press,
  output logic [1:0] result,
  output logic       hit_clear
);

  logic btn_q;

  assign press = btn & ~btn_q;

  // Edge register plus stage-1 judgement; zone flags are taken in the press cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q     <= 1'b0;
      result    <= JUDGE_NONE;
      hit_clear <= 1'b0;
    end else begin
      btn_q     <= btn;
      result    <= JUDGE_NONE;
      hit_clear <= 1'b0;
      if (enable && press) begin
        if (perfect) begin
          result    <= JUDGE_PERFECT;
          hit_clear <= 1'b1;
        end else if (in_zone) begin
          result    <= JUDGE_GOOD;
          hit_clear <= 1'b1;
        end else begin
          result    <= JUDGE_MISS;
        end
      end
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Hit judge for the DDR game: judges presses against arrows in the target
// zone, keeps score and combo, and sequences IDLE / PLAY / HOLD.
// Optional build macro HIT_JUDGE_MISS_PENALTY_EN: each bad-press MISS takes
// one point off the score (floored at 0); without it score never decreases.
import ddr_pkg::*;

module hit_judge #(
  parameter int PERFECT_PTS = 2,
  parameter int GOOD_PTS    = 1,
  parameter int COMBO_STEP  = 10,
  parameter int MAX_MULT    = 4,
  parameter int SCORE_MAX   = SCORE_MAX_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [3:0]  arrow_in_zone,
  input  logic [3:0]  arrow_perfect,
  input  logic [3:0]  arrow_missed,
  input  logic        game_over,
  output logic [3:0]  hit_clear,
  output logic [1:0]  judge,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic        playing
);

  state_t      state;
  logic [3:0]  press;
  logic [1:0]  result [4];
  logic        stage1_en;
  logic        missed_q;
  logic        any_press;

  logic [7:0]  base;
  logic [3:0]  n_hits;
  logic [3:0]  n_miss;
  logic        any_good;
  logic        any_miss;
  logic [7:0]  mult;
  logic [15:0] delta;
  logic [16:0] sum;
  logic [16:0] sum_adj;
  logic [8:0]  combo_sum;
  logic [15:0] score_next;
  logic [7:0]  combo_next;
  logic [1:0]  judge_next;

  // Presses only count while playing; game_over in the same cycle wins.
  assign stage1_en = (state == PLAY) && !game_over;
  assign any_press = |press;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_classify u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn[i]),
      .in_zone   (arrow_in_zone[i]),
      .perfect   (arrow_perfect[i]),
      .enable    (stage1_en),
      .press     (press[i]),
      .result    (result[i]),
      .hit_clear (hit_clear[i])
    );
  end

  // Arrow-missed pulses ride stage 1 so they combine with presses of the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) missed_q <= 1'b0;
    else        missed_q <= stage1_en && (|arrow_missed);
  end

  // Stage-2 arithmetic: base points, multiplier, clamped score and combo.
  always_comb begin
    base     = 8'd0;
    n_hits   = 4'd0;
    n_miss   = 4'd0;
    any_good = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (result[i])
        JUDGE_PERFECT: begin
          base   = base + 8'(PERFECT_PTS);
          n_hits = n_hits + 4'd1;
        end
        JUDGE_GOOD: begin
          base     = base + 8'(GOOD_PTS);
          n_hits   = n_hits + 4'd1;
          any_good = 1'b1;
        end
        JUDGE_MISS: n_miss = n_miss + 4'd1;
        default: ;
      endcase
    end

    any_miss = (n_miss != 4'd0) || missed_q;
    mult     = combo_mult(combo, COMBO_STEP, MAX_MULT);
    delta    = 16'(base) * 16'(mult);
    sum      = {1'b0, score} + {1'b0, delta};

`ifdef HIT_JUDGE_MISS_PENALTY_EN
    if (sum < 17'(n_miss)) sum_adj = 17'd0;
    else                   sum_adj = sum - 17'(n_miss);
`else
    sum_adj = sum;
`endif

    if (sum_adj > 17'(SCORE_MAX)) score_next = 16'(SCORE_MAX);
    else                          score_next = sum_adj[15:0];

    combo_sum = {1'b0, combo} + 9'(n_hits);
    if (any_miss)                combo_next = 8'd0;
    else if (combo_sum > 9'd255) combo_next = 8'd255;
    else                         combo_next = combo_sum[7:0];

    if (any_miss)           judge_next = JUDGE_MISS;
    else if (any_good)      judge_next = JUDGE_GOOD;
    else if (n_hits != 4'd0) judge_next = JUDGE_PERFECT;
    else                    judge_next = judge;
  end

  // Game FSM with registered score, combo, judge and playing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      playing <= 1'b0;
      score   <= 16'd0;
      combo   <= 8'd0;
      judge   <= JUDGE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (any_press) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          score <= score_next;
          combo <= combo_next;
          judge <= judge_next;
          if (game_over) begin
            state   <= HOLD;
            playing <= 1'b0;
          end
        end
        HOLD: begin
          if (any_press) begin
            state <= IDLE;
            score <= 16'd0;
            combo <= 8'd0;
            judge <= JUDGE_NONE;
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule
